// File: rtl/s8_jk.sv
// s8_jk: single-bit JK flip-flop with asynchronous active-low clear (rst)
// and preset (set). Clear dominates preset. qb is always the exact
// complement of q and is never stored separately.
module s8_jk (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    input  logic set,
    output logic q,
    output logic qb
);

    // Effective preset: only active while clear is released. Masking it
    // with rst means that releasing rst while set is still low produces a
    // falling edge here. That edge re-triggers the flop and forces q=1 at
    // once, instead of leaving q at 0 until the next clock.
    logic set_eff;
    assign set_eff = set | ~rst;

    // State bit: async clear, then async preset, else JK on rising clk.
    always_ff @(posedge clk or negedge rst or negedge set_eff) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (!set_eff) begin
            q <= 1'b1;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

    // Complementary output, derived from q only.
    assign qb = ~q;

endmodule

// File: tb/tb_s8_jk.sv
// tb_s8_jk: self-checking bench for s8_jk. It uses a truth-table vector
// array, directed async sequences, randomized stimulus against a reference
// model, and a free-running timed pattern.
module tb_s8_jk;

    logic clk = 1'b0;
    logic rst, j, k, set;
    logic q, qb;

    int checks = 0;
    int errors = 0;
    logic ref_q;

    typedef struct {
        logic j;
        logic k;
        logic exp;
    } vec_t;

    vec_t tv[9];

    s8_jk dut (
        .clk (clk),
        .rst (rst),
        .j   (j),
        .k   (k),
        .set (set),
        .q   (q),
        .qb  (qb)
    );

    // 20 ns clock, rising edges at 10, 30, 50, ...
    always #10 clk = ~clk;

    // Characteristic equation of a JK flip-flop.
    function automatic logic jk_next(input logic cur, input logic jj, input logic kk);
        return (jj & ~cur) | (~kk & cur);
    endfunction

    task automatic chk(input string nm, input logic exp);
        checks++;
        if (q !== exp || qb !== ~exp) begin
            errors++;
            $display("FAIL %s at %0t: q=%b qb=%b, expected q=%b qb=%b",
                     nm, $time, q, qb, exp, ~exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        // Truth table from q=0, then a toggle run of four edges from q=0.
        tv[0] = '{1'b1, 1'b0, 1'b1};
        tv[1] = '{1'b0, 1'b0, 1'b1};
        tv[2] = '{1'b0, 1'b1, 1'b0};
        tv[3] = '{1'b1, 1'b1, 1'b1};
        tv[4] = '{1'b1, 1'b1, 1'b0};
        tv[5] = '{1'b1, 1'b1, 1'b1};
        tv[6] = '{1'b1, 1'b1, 1'b0};
        tv[7] = '{1'b1, 1'b1, 1'b1};
        tv[8] = '{1'b1, 1'b1, 1'b0};

        // Clear with the clock running and j/k asserted.
        rst = 1'b0; set = 1'b1; j = 1'b1; k = 1'b1;
        #3 chk("clear_immediate", 1'b0);
        tick; chk("clear_edge1", 1'b0);
        tick; chk("clear_edge2", 1'b0);
        rst = 1'b1; j = 1'b0; k = 1'b0;
        tick; chk("clear_release_hold", 1'b0);

        // JK truth table and toggle run.
        for (int i = 0; i < 9; i++) begin
            j = tv[i].j; k = tv[i].k;
            tick;
            chk($sformatf("table_%0d_jk%b%b", i, tv[i].j, tv[i].k), tv[i].exp);
        end

        // Preset mid-cycle, held across edges with j=0, k=1.
        #5 set = 1'b0;
        #1 chk("preset_immediate", 1'b1);
        j = 1'b0; k = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick; chk("preset_hold_edge", 1'b1);
        end
        set = 1'b1; j = 1'b0; k = 1'b0;
        tick; chk("preset_release_hold", 1'b1);
        set = 1'b0; #1;
        set = 1'b1; j = 1'b1; k = 1'b1;
        tick; chk("preset_release_toggle", 1'b0);

        // Both asserted: clear dominates. Releasing rst first gives preset.
        rst = 1'b0; set = 1'b0;
        #1 chk("both_low", 1'b0);
        tick; chk("both_low_edge", 1'b0);
        rst = 1'b1;
        #1 chk("rst_release_set_low", 1'b1);
        set = 1'b1; j = 1'b1; k = 1'b1;
        tick; chk("set_release_toggle", 1'b0);

        // A falling edge must not toggle.
        @(negedge clk); #1 chk("negedge_no_effect", 1'b0);
        tick; chk("posedge_after_negedge", 1'b1);

        // Randomized stimulus against the reference model.
        ref_q = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            j = 1'($urandom); k = 1'($urandom);
            rst = (r == 0 || r == 3) ? 1'b0 : 1'b1;
            set = (r == 1 || r == 2 || r == 3) ? 1'b0 : 1'b1;
            #1;
            ref_q = !rst ? 1'b0 : (!set ? 1'b1 : ref_q);
            chk("rand_async", ref_q);
            @(posedge clk);
            ref_q = !rst ? 1'b0 : (!set ? 1'b1 : jk_next(ref_q, j, k));
            #1 chk("rand_edge", ref_q);
        end

        // Free-running pattern. t0 is aligned so that edges fall at t0+5+20n,
        // away from every stimulus change.
        rst = 1'b1; set = 1'b1; j = 1'b0; k = 1'b0;
        tick;
        ref_q = q === 1'b1 ? 1'b1 : 1'b0;
        chk("free_start", ref_q);
        @(posedge clk); #15;
        fork
            begin
                for (int t = 0; t < 12; t++) begin
                    #20 j = ~j;
                end
            end
            begin
                for (int t = 0; t < 8; t++) begin
                    #30 k = ~k;
                end
            end
            begin
                #50 set = 1'b0;
                #1 chk("free_set_async", 1'b1);
                #49 set = 1'b1;
                #50 rst = 1'b0;
                #1 chk("free_rst_async", 1'b0);
                #49 rst = 1'b1;
            end
            begin
                for (int e = 0; e < 12; e++) begin
                    @(posedge clk);
                    ref_q = !rst ? 1'b0 : (!set ? 1'b1 : jk_next(ref_q, j, k));
                    #1 chk($sformatf("free_edge_%0d", e), ref_q);
                end
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
